bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter for the seven-segment/debug display path.
//  Uses shift-add-3 (double-dabble) and retires one input bit per clock, so area stays
//  independent of BIN_W. Optional signed mode outputs magnitude plus a sign flag.
//  Adds an overflow flag and a valid/ready handshake on both input and output sides.
// PARAMETERS
//  BIN_W   14  width of binary input, 2..32
//  DIGITS  5   number of BCD digits produced; bcd output is 4*DIGITS bits
//  SIGNED  0   0: bin is unsigned; 1: bin is two's complement, output is |bin| plus neg flag
// PORTS
//  clk        in   1         system clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         bin holds a value to be converted
//  in_ready   out  1         converter can accept; high only in IDLE
//  bin        in   BIN_W     binary value, sampled on the accept edge only
//  out_valid  out  1         bcd/neg/ovf hold a finished result
//  out_ready  in   1         consumer takes the result
//  bcd        out  4*DIGITS  packed BCD, digit 0 (units) in [3:0]
//  neg        out  1         SIGNED=1 and input was negative; always 0 when SIGNED=0
//  ovf        out  1         |bin| >= 10**DIGITS; bcd then holds the truncated low digits
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset: state=IDLE, in_ready=1, out_valid=0, bcd=0, neg=0, ovf=0, bit counter=0.
//  FSM states are IDLE, SHIFT and DONE.
//  IDLE: in_ready=1.
//   - On in_valid&in_ready: load shift reg with mag, clear BCD accumulator, ovf<=0,
//     neg<=SIGNED&bin[BIN_W-1], cnt<=BIN_W, go to SHIFT.
//   - mag = (SIGNED && bin[MSB]) ? -bin : bin, taken as BIN_W-bit unsigned.
//   - Most-negative input (-2**(BIN_W-1)) gives mag=2**(BIN_W-1). Correct, no wrap.
//  SHIFT: in_ready=0. Each cycle:
//   - First, every digit >=5 gets +3 (4-bit add, no carry between digits).
//   - Then {acc,shift} shifts left by 1. The MSB of shift enters acc[0], cnt decrements.
//   - The bit shifted out of acc[4*DIGITS-1] is ORed into ovf (sticky for this conversion).
//   - When cnt reaches 1 and that shift completes, go to DONE.
//  DONE: out_valid=1. bcd, neg and ovf stay stable while out_valid&!out_ready.
//   - On out_ready: out_valid<=0, go to IDLE.
//   - bcd/neg/ovf keep their values until the next accept.
//  Latency: out_valid rises exactly BIN_W clocks after the accept edge.
//   - Throughput is one result per BIN_W+2 clocks at best. Conversions never overlap.
//  Simultaneous events:
//   - in_valid during SHIFT/DONE is ignored (in_ready=0). bin is not sampled.
//   - in_valid and out_ready together in DONE: only the output handshake completes this
//     cycle. The input is accepted in IDLE on the next cycle.
//  Reset mid-operation: the conversion is aborted and all outputs return to reset values.
//   - No partial result is ever presented.
//  bcd is a registered output. No combinational path from bin to any output.
//  DIGITS must be >= 1. The bcd digit values are always 0..9, including when ovf=1.
// TESTING
//  1. Defaults, bin=9999 accepted at edge T -> out_valid at T+14, bcd=20'h09999, ovf=0.
//  2. Defaults, bin=16383 -> bcd=20'h16383, then bin=0 -> bcd=20'h00000.
//     Each result takes exactly 14 clocks.
//  3. Hold out_ready=0 for 5 clocks in DONE, with in_valid=1 throughout:
//     -> bcd stable, in_ready=0, no new accept.
//     -> Accept occurs 1 clock after out_ready.
//  4. SIGNED=1, BIN_W=8, DIGITS=3:
//     -> bin=8'h80 gives bcd=12'h128, neg=1.
//     -> bin=8'h7F gives bcd=12'h127, neg=0.
//     -> bin=8'hFF gives bcd=12'h001, neg=1.
//  5. DIGITS=3, bin=16383 -> ovf=1, bcd=12'h383.
//     Next input bin=999 -> ovf=0, bcd=12'h999.
//  6. Assert rst_n=0 for one half-cycle after the 6th SHIFT cycle:
//     -> outputs reset immediately, state IDLE.
//     -> A new conversion of 42 then gives bcd=20'h00042.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit retired per clock.
// Optional signed mode yields magnitude plus neg flag; ovf flags truncated high digits.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// SHIFT | add-3 then shift, one bit per clock, BIN_W clocks
// DONE  | result presented on bcd/neg/ovf until out_ready
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] sh_q;
  logic [BIN_W-1:0] mag;
  logic [BW-1:0]    acc_q;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    acc_nxt;
  logic [CW-1:0]    cnt_q;
  logic             wneg_q;
  logic             wovf_q;
  logic             out_bit;
  logic             accept;
  logic             last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state_q == SHIFT) && (cnt_q == CW'(1));

  // Most-negative input negates to 2**(BIN_W-1), which still fits as unsigned.
  assign mag = (SIGNED && bin[BIN_W-1]) ? (~bin + BIN_W'(1)) : bin;

  always_comb begin
    adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
    acc_nxt = {adj[BW-2:0], sh_q[BIN_W-1]};
    out_bit = adj[BW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Working registers change during SHIFT; bcd/neg/ovf only load on the final shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      wneg_q <= 1'b0;
      wovf_q <= 1'b0;
      bcd    <= '0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      sh_q   <= mag;
      acc_q  <= '0;
      cnt_q  <= CW'(BIN_W);
      wneg_q <= SIGNED & bin[BIN_W-1];
      wovf_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      sh_q   <= {sh_q[BIN_W-2:0], 1'b0};
      acc_q  <= acc_nxt;
      cnt_q  <= cnt_q - CW'(1);
      wovf_q <= wovf_q | out_bit;
      if (last) begin
        bcd <= acc_nxt;
        neg <= wneg_q;
        ovf <= wovf_q | out_bit;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: default, signed 8-bit/3-digit and 3-digit overflow builds.
module tb_bin2bcd_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel   = 2'd0;
  logic        iv    = 1'b0;
  logic        ordy  = 1'b0;
  logic [13:0] bn    = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic        ir0, ov0, ng0, of0;
  logic [19:0] bcd0;
  logic        ir1, ov1, ng1, of1;
  logic [11:0] bcd1;
  logic        ir2, ov2, ng2, of2;
  logic [11:0] bcd2;

  bin2bcd_seq u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv && sel == 2'd0), .in_ready(ir0), .bin(bn),
    .out_valid(ov0), .out_ready(ordy && sel == 2'd0),
    .bcd(bcd0), .neg(ng0), .ovf(of0)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv && sel == 2'd1), .in_ready(ir1), .bin(bn[7:0]),
    .out_valid(ov1), .out_ready(ordy && sel == 2'd1),
    .bcd(bcd1), .neg(ng1), .ovf(of1)
  );

  bin2bcd_seq #(.BIN_W(14), .DIGITS(3), .SIGNED(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv && sel == 2'd2), .in_ready(ir2), .bin(bn),
    .out_valid(ov2), .out_ready(ordy && sel == 2'd2),
    .bcd(bcd2), .neg(ng2), .ovf(of2)
  );

  logic        ir_m, ov_m, ng_m, of_m;
  logic [19:0] bcd_m;
  assign ir_m  = (sel == 2'd0) ? ir0 : (sel == 2'd1) ? ir1 : ir2;
  assign ov_m  = (sel == 2'd0) ? ov0 : (sel == 2'd1) ? ov1 : ov2;
  assign ng_m  = (sel == 2'd0) ? ng0 : (sel == 2'd1) ? ng1 : ng2;
  assign of_m  = (sel == 2'd0) ? of0 : (sel == 2'd1) ? of1 : of2;
  assign bcd_m = (sel == 2'd0) ? bcd0 : (sel == 2'd1) ? {8'h00, bcd1} : {8'h00, bcd2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents b at a falling edge; returns at the falling edge just after the accept edge.
  task automatic start(input logic [13:0] b);
    @(negedge clk);
    iv = 1'b1;
    bn = b;
    chk("in_ready_idle", 32'(ir_m), 32'd1);
    @(negedge clk);
    iv = 1'b0;
    chk("in_ready_busy", 32'(ir_m), 32'd0);
  endtask

  // Counts clocks from the accept edge until out_valid is seen.
  task automatic wait_done(input int lat);
    int k = 0;
    while (!ov_m && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat));
  endtask

  task automatic take();
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("out_valid_drop", 32'(ov_m), 32'd0);
  endtask

  task automatic conv(input logic [13:0] b, input int lat,
                      input logic [19:0] e_bcd, input logic e_neg, input logic e_ovf);
    start(b);
    wait_done(lat);
    chk("bcd", 32'(bcd_m), 32'(e_bcd));
    chk("neg", 32'(ng_m), 32'(e_neg));
    chk("ovf", 32'(of_m), 32'(e_ovf));
    take();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(ir0), 32'd1);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_bcd", 32'(bcd0), 32'd0);
    chk("rst_neg_ovf", 32'({ng0, of0}), 32'd0);
    rst_n = 1'b1;

    sel = 2'd0;
    conv(14'd9999,  14, 20'h09999, 1'b0, 1'b0);
    conv(14'd16383, 14, 20'h16383, 1'b0, 1'b0);
    conv(14'd0,     14, 20'h00000, 1'b0, 1'b0);

    // Back-pressure in DONE with in_valid held high.
    start(14'd5000);
    wait_done(14);
    chk("bp_bcd", 32'(bcd_m), 32'h05000);
    iv = 1'b1;
    bn = 14'd1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_bcd", 32'(bcd_m), 32'h05000);
      chk("bp_hold_in_ready", 32'(ir_m), 32'd0);
      chk("bp_hold_out_valid", 32'(ov_m), 32'd1);
    end
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("bp_idle_in_ready", 32'(ir_m), 32'd1);
    chk("bp_idle_out_valid", 32'(ov_m), 32'd0);
    @(negedge clk);
    iv = 1'b0;
    chk("bp_accept", 32'(ir_m), 32'd0);
    wait_done(14);
    chk("bp_next_bcd", 32'(bcd_m), 32'h01234);
    take();

    sel = 2'd1;
    conv(14'h0080, 8, 20'h00128, 1'b1, 1'b0);
    conv(14'h007F, 8, 20'h00127, 1'b0, 1'b0);
    conv(14'h00FF, 8, 20'h00001, 1'b1, 1'b0);

    sel = 2'd2;
    conv(14'd16383, 14, 20'h00383, 1'b0, 1'b1);
    conv(14'd999,   14, 20'h00999, 1'b0, 1'b0);

    // Reset pulse part-way through a conversion.
    sel = 2'd0;
    start(14'd12345);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ov_m), 32'd0);
    chk("mid_rst_in_ready", 32'(ir_m), 32'd1);
    chk("mid_rst_bcd", 32'(bcd_m), 32'd0);
    chk("mid_rst_neg_ovf", 32'({ng_m, of_m}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv(14'd42, 14, 20'h00042, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
